// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multicycle radix-2 restoring divider for MIPS DIV/DIVU.
//                The divider takes one quotient bit per cycle and writes LO
//                with the quotient and HI with the remainder.
//                Optional build macro DIV_ZERO_FAST_EN makes a zero divisor
//                complete straight from PREP, with quotient = all ones and
//                remainder = the raw dividend.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_CALC = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [CNT_W-1:0]  c_CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] c_ONE      = DATA_W'(1);

    logic [2:0]        r_state;
    logic              r_sign;
    logic              r_negq;
    logic              r_negr;
    logic [DATA_W-1:0] r_a;          // raw latched dividend
    logic [DATA_W-1:0] r_b;          // latched divisor, replaced by its magnitude in PREP
    logic [DATA_W-1:0] r_quo_work;   // dividend bits shift out the top, quotient bits in the bottom
    logic [DATA_W-1:0] r_rem_work;   // partial remainder; always below the divisor between steps
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quotient;
    logic [DATA_W-1:0] r_remainder;

    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_trial;
    logic [DATA_W-1:0] w_rem_restore;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    // Operand magnitudes, one restoring step and the final sign correction.
    always_comb begin
        w_a_mag       = (r_sign && r_a[DATA_W-1]) ? (~r_a + c_ONE) : r_a;
        w_b_mag       = (r_sign && r_b[DATA_W-1]) ? (~r_b + c_ONE) : r_b;
        // The shifted partial remainder is DATA_W+1 bits wide; its sign after
        // subtracting the divisor decides between keeping and restoring.
        w_trial       = {r_rem_work, r_quo_work[DATA_W-1]} - {1'b0, r_b};
        w_rem_restore = {r_rem_work[DATA_W-2:0], r_quo_work[DATA_W-1]};
        w_q_fix       = r_negq ? (~r_quo_work + c_ONE) : r_quo_work;
        w_r_fix       = r_negr ? (~r_rem_work + c_ONE) : r_rem_work;
    end

    // Control FSM, datapath registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sign      <= 1'b0;
            r_negq      <= 1'b0;
            r_negr      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_quo_work  <= '0;
            r_rem_work  <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (cancel) begin
            // A flush abandons the operation; the previous results stay visible.
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= dividend;
                        r_b     <= divisor;
                        r_sign  <= sign;
                        r_state <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    r_quo_work <= w_a_mag;
                    r_b        <= w_b_mag;
                    r_rem_work <= '0;
                    r_negq     <= r_sign & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
                    r_negr     <= r_sign & r_a[DATA_W-1];
                    r_cnt      <= c_CNT_LOAD;
`ifdef DIV_ZERO_FAST_EN
                    if (r_b == '0) begin
                        r_quotient  <= '1;
                        r_remainder <= r_a;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_state <= c_ST_CALC;
                    end
`else
                    r_state    <= c_ST_CALC;
`endif
                end
                c_ST_CALC: begin
                    if (w_trial[DATA_W]) begin
                        r_rem_work <= w_rem_restore;
                        r_quo_work <= {r_quo_work[DATA_W-2:0], 1'b0};
                    end else begin
                        r_rem_work <= w_trial[DATA_W-1:0];
                        r_quo_work <= {r_quo_work[DATA_W-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_state     <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == c_ST_PREP) || (r_state == c_ST_CALC) || (r_state == c_ST_FIX);
    assign done      = (r_state == c_ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed vector table,
//                multi-cycle corner sequences and randomized operands compared
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_q  = '0;
    logic [31:0] last_r  = '0;

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with the divide-by-zero rules.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa;
        longint sb;
        longint tq;
        longint tr;
        lat = 35;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 2;
`else
            r = a;
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one operation, scramble inputs after the latch, track busy and
    // latency, then hold start through the DONE cycle to confirm it is ignored.
    task automatic run_op(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input int elat, input bit poke);
        int cyc;
        int busy_bad;
        bit seen;
        @(negedge clk);
        start = 1'b1; sign = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        cyc = 1; busy_bad = 0; seen = 1'b0;
        start = 1'b0; sign = ~s; dividend = $urandom; divisor = $urandom;
        while (!seen && cyc < 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                if (poke && cyc == 10) start = 1'b1;
                if (poke && cyc == 11) start = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({name, " done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check({name, " latency"}, cyc, elat);
            check({name, " quotient"}, quotient, eq);
            check({name, " remainder"}, remainder, er);
            check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
            check({name, " busy_gaps"}, busy_bad, 32'd0);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
            check({name, " start_in_done_ignored"}, {31'b0, busy}, 32'd0);
            check({name, " quotient_held"}, quotient, eq);
        end
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          elat;
        int          done_cnt;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; sign = 1'b0;
        dividend = '0; divisor = '0;

        vecs.push_back('{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          35});
        vecs.push_back('{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  35});
        vecs.push_back('{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          35});
        vecs.push_back('{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          35});
        vecs.push_back('{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          35});
        vecs.push_back('{"divu_max_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          35});
        vecs.push_back('{"div_m1_m1",    1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          35});
        vecs.push_back('{"div_0_5",      1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          35});
`ifdef DIV_ZERO_FAST_EN
        vecs.push_back('{"divu_by_zero", 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  2});
        vecs.push_back('{"div_neg_by_0", 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  2});
`else
        vecs.push_back('{"divu_by_zero", 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  35});
        vecs.push_back('{"div_neg_by_0", 1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB,  35});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.name, v.s, v.a, v.b, v.exp_q, v.exp_r, v.exp_lat, 1'b0);
        end

        // start pulses while busy are ignored
        run_op("poke_div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'd0, 35, 1'b1);

        // Cancel at cycle 10: busy drops next cycle, no done, results held
        @(negedge clk);
        start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel busy_low", {31'b0, busy}, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        check("cancel no_done", done_cnt, 32'd0);
        check("cancel quotient_kept", quotient, last_q);
        check("cancel remainder_kept", remainder, last_r);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, 1'b0);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rs, ra, rb, eq, er, elat);
            run_op($sformatf("rand%0d", i), rs, ra, rb, eq, er, elat, 1'b0);
        end

        // Reset in the middle of CALC clears everything
        @(negedge clk);
        start = 1'b1; sign = 1'b0; dividend = 32'd12345; divisor = 32'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_calc busy", {31'b0, busy}, 32'd0);
        check("rst_calc done", {31'b0, done}, 32'd0);
        check("rst_calc quotient", quotient, 32'd0);
        check("rst_calc remainder", remainder, 32'd0);

        // start together with cancel in IDLE is not accepted
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; sign = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel busy0", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("start_cancel busy1", {31'b0, busy}, 32'd0);
        run_op("after_start_cancel", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 35, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
